// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
//   Shares one external combinational ALU between two requester ports.
//   A granted request is computed by the ALU in the grant cycle and the
//   result is registered and presented to the owning port until it is
//   accepted. A new request may be granted in the same cycle the current
//   owner accepts its response, giving one result per cycle when streaming.
//
//   Configuration macro: ALU_ARB_FIXED_PRIO_EN
//     undefined : round-robin tie break (last_grant register, port 0 first)
//     defined   : fixed priority, port 0 always wins ties
//
// Ports
//   clk, rst_n                       clock, async active-low reset
//   req_valid_i[1:0] / req_ready_o    per-port request handshake
//   req{0,1}_a_i, _b_i, _op_i         per-port operands and opcode
//   resp_valid_o[1:0] / resp_ready_i  per-port response handshake
//   resp_data_o, resp_zero_o          registered ALU result / zero flag
//   alu_a_o, alu_b_o, alu_op_o        operands to the external ALU
//   alu_result_i, alu_zero_i          combinational ALU outputs
// ---------------------------------------------------------------------------
module alu_arbiter #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        req_valid_i,
  output logic [1:0]        req_ready_o,
  input  logic [DATA_W-1:0] req0_a_i,
  input  logic [DATA_W-1:0] req0_b_i,
  input  logic [OP_W-1:0]   req0_op_i,
  input  logic [DATA_W-1:0] req1_a_i,
  input  logic [DATA_W-1:0] req1_b_i,
  input  logic [OP_W-1:0]   req1_op_i,
  output logic [1:0]        resp_valid_o,
  input  logic [1:0]        resp_ready_i,
  output logic [DATA_W-1:0] resp_data_o,
  output logic              resp_zero_o,
  output logic [DATA_W-1:0] alu_a_o,
  output logic [DATA_W-1:0] alu_b_o,
  output logic [OP_W-1:0]   alu_op_o,
  input  logic [DATA_W-1:0] alu_result_i,
  input  logic              alu_zero_i
);

  // state | meaning
  // IDLE  | no response held
  // RESP  | one response held for port owner_q
  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic                owner_q, owner_d;
  logic [DATA_W-1:0]   resp_data_q, resp_data_d;
  logic                resp_zero_q, resp_zero_d;

  logic                grantable;
  logic                grant;
  logic                winner;
  logic                sel;
  logic                tie_pick;
  logic                idle_sel;

`ifdef ALU_ARB_FIXED_PRIO_EN
  assign tie_pick = 1'b0;
  assign idle_sel = 1'b0;
`else
  logic last_grant_q, last_grant_d;

  assign tie_pick = ~last_grant_q;
  assign idle_sel = last_grant_q;
`endif

  // Gating with rst_n keeps req_ready low for the whole reset window,
  // not just after the first edge.
  always_comb begin
    grantable = rst_n && ((state_q == IDLE) || resp_ready_i[owner_q]);
    // With a single requester, req_valid_i[1] alone names the winner.
    winner    = (req_valid_i == 2'b11) ? tie_pick : req_valid_i[1];
    grant     = grantable && (req_valid_i != 2'b00);
    sel       = grant ? winner : idle_sel;
  end

  always_comb begin
    if (sel) begin
      alu_a_o  = req1_a_i;
      alu_b_o  = req1_b_i;
      alu_op_o = req1_op_i;
    end else begin
      alu_a_o  = req0_a_i;
      alu_b_o  = req0_b_i;
      alu_op_o = req0_op_i;
    end
  end

  always_comb begin
    req_ready_o  = 2'b00;
    resp_valid_o = 2'b00;
    if (grant) begin
      req_ready_o = winner ? 2'b10 : 2'b01;
    end
    if (state_q == RESP) begin
      resp_valid_o = owner_q ? 2'b10 : 2'b01;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    resp_data_d = resp_data_q;
    resp_zero_d = resp_zero_q;
`ifndef ALU_ARB_FIXED_PRIO_EN
    last_grant_d = last_grant_q;
`endif
    if (grant) begin
      state_d     = RESP;
      owner_d     = winner;
      resp_data_d = alu_result_i;
      resp_zero_d = alu_zero_i;
`ifndef ALU_ARB_FIXED_PRIO_EN
      last_grant_d = winner;
`endif
    end else if ((state_q == RESP) && resp_ready_i[owner_q]) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      resp_data_q <= '0;
      resp_zero_q <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
      last_grant_q <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      resp_data_q <= resp_data_d;
      resp_zero_q <= resp_zero_d;
`ifndef ALU_ARB_FIXED_PRIO_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  assign resp_data_o = resp_data_q;
  assign resp_zero_o = resp_zero_q;

endmodule
